// File: rtl/mem_burst_interface.sv
// Word-wide memory transfer split into BEATS narrow beats on a byte-wide memory port.
// The memory stalls with mem_rdy; a beat that stalls past WAIT_MAX cycles aborts the
// transfer and sets err. Every output is decoded from registered state only.
module mem_burst_interface #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned BYTE_W   = 8,
  parameter int unsigned BEATS    = 4,
  parameter int unsigned WAIT_MAX = 15,
  localparam int unsigned BW      = $clog2(BEATS),
  localparam int unsigned WORD_W  = BYTE_W * BEATS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 wr,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic [WORD_W-1:0]    wdata,
  input  logic                 mem_rdy,
  input  logic [BYTE_W-1:0]    mem_din,
  output logic [ADDR_W+BW-1:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [BYTE_W-1:0]    mem_dout,
  output logic [WORD_W-1:0]    rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WaitMax  = WW'(WAIT_MAX);
  localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  // Next-state logic: operand capture, beat sequencing and stall timeout.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = addr_in;
          wdata_d = wdata;
          wr_d    = wr;
          beat_d  = '0;
          wait_d  = '0;
          err_d   = 1'b0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (mem_rdy) begin
          // mem_din is ignored on writes so rdata only changes on read beats.
          if (!wr_q) rdata_d[beat_q*BYTE_W +: BYTE_W] = mem_din;
          wait_d = '0;
          if (beat_q == LastBeat) state_d = StDone;
          else                    beat_d  = beat_q + BW'(1);
        end else if (wait_q == WaitMax) begin
          // Captured slices stay; uncaptured slices keep their previous contents.
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset beats any start or mem_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      beat_q  <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Output decode from registers only; memory port is quiet outside XFER.
  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_dout = '0;
    if (state_q == StXfer) begin
      mem_rd   = ~wr_q;
      mem_wr   = wr_q;
      mem_addr = {addr_q, beat_q};
      mem_dout = wdata_q[beat_q*BYTE_W +: BYTE_W];
    end
    busy  = (state_q != StIdle);
    done  = (state_q == StDone);
    rdata = rdata_q;
    err   = err_q;
  end

endmodule

// File: tb/tb_mem_burst_interface.sv
// Directed bench: default instance (read, stalled write, protocol, reset),
// a WAIT_MAX=3 instance (timeout) and a BEATS=8/BYTE_W=4 instance.
module tb_mem_burst_interface;

  logic        clk = 1'b0;
  logic        rst, wr, mem_rdy;
  logic        start0, start1, start2;
  logic [15:0] addr_in;
  logic [31:0] wdata;
  logic [7:0]  mem_din;

  logic [17:0] mem_addr0, mem_addr1;
  logic [18:0] mem_addr2;
  logic        mem_rd0, mem_wr0, busy0, done0, err0;
  logic        mem_rd1, mem_wr1, busy1, done1, err1;
  logic        mem_rd2, mem_wr2, busy2, done2, err2;
  logic [7:0]  mem_dout0, mem_dout1;
  logic [3:0]  mem_dout2;
  logic [31:0] rdata0, rdata1, rdata2;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] wexp;

  always #5 clk = ~clk;

  mem_burst_interface u_def (
    .clk(clk), .rst(rst), .start(start0), .wr(wr), .addr_in(addr_in), .wdata(wdata),
    .mem_rdy(mem_rdy), .mem_din(mem_din), .mem_addr(mem_addr0), .mem_rd(mem_rd0),
    .mem_wr(mem_wr0), .mem_dout(mem_dout0), .rdata(rdata0), .busy(busy0), .done(done0),
    .err(err0)
  );

  mem_burst_interface #(.WAIT_MAX(3)) u_to (
    .clk(clk), .rst(rst), .start(start1), .wr(wr), .addr_in(addr_in), .wdata(wdata),
    .mem_rdy(mem_rdy), .mem_din(mem_din), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
    .mem_wr(mem_wr1), .mem_dout(mem_dout1), .rdata(rdata1), .busy(busy1), .done(done1),
    .err(err1)
  );

  mem_burst_interface #(.BEATS(8), .BYTE_W(4)) u_b8 (
    .clk(clk), .rst(rst), .start(start2), .wr(wr), .addr_in(addr_in), .wdata(wdata),
    .mem_rdy(mem_rdy), .mem_din(mem_din[3:0]), .mem_addr(mem_addr2), .mem_rd(mem_rd2),
    .mem_wr(mem_wr2), .mem_dout(mem_dout2), .rdata(rdata2), .busy(busy2), .done(done2),
    .err(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 0; start1 = 0; start2 = 0; wr = 0; mem_rdy = 0;
    addr_in = '0; wdata = '0; mem_din = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_rdata", rdata0, 0);
    chk("rst_mem_rd", mem_rd0, 0);
    chk("rst_mem_addr", mem_addr0, 0);

    // Read, mem_rdy held high.
    start0 = 1; wr = 0; addr_in = 16'h1234; mem_rdy = 1;
    tick();
    start0 = 0;
    chk("rd_busy", busy0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("rd_addr", mem_addr0, {16'h1234, 2'(i)});
      chk("rd_strobe", {mem_rd0, mem_wr0}, 2'b10);
      chk("rd_no_done", done0, 0);
      mem_din = 8'h11 * 8'(i + 1);
      tick();
    end
    chk("rd_done", done0, 1);
    chk("rd_rdata", rdata0, 32'h44332211);
    chk("rd_err", err0, 0);
    chk("rd_idle_addr", mem_addr0, 0);
    // Start during DONE is ignored.
    start0 = 1; addr_in = 16'hFFFF;
    tick();
    start0 = 0;
    chk("done_start_ign", busy0, 0);
    chk("done_pulse_one", done0, 0);

    // Write with two stall cycles before each beat; start pulsed mid-transfer.
    wexp = 32'hA1B2C3D4;
    start0 = 1; wr = 1; addr_in = 16'h0042; wdata = wexp; mem_rdy = 0; mem_din = 8'hFF;
    tick();
    start0 = 0;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < 3; s++) begin
        chk("wr_dout", mem_dout0, wexp[b*8 +: 8]);
        chk("wr_addr", mem_addr0, {16'h0042, 2'(b)});
        chk("wr_strobe", {mem_rd0, mem_wr0}, 2'b01);
        chk("wr_no_done", done0, 0);
        if (b == 1 && s == 0) begin
          start0 = 1; wr = 0; addr_in = 16'hFFFF; wdata = 32'h0;
        end
        mem_rdy = (s == 2);
        tick();
        start0 = 0;
      end
    end
    mem_rdy = 0;
    chk("wr_done", done0, 1);
    chk("wr_rdata_keep", rdata0, 32'h44332211);
    chk("wr_err", err0, 0);
    tick();

    // Timeout instance: fill rdata, then abort on beat 1.
    start1 = 1; wr = 0; addr_in = 16'h0000; mem_rdy = 1;
    tick();
    start1 = 0;
    for (int i = 0; i < 4; i++) begin
      mem_din = 8'hAA + 8'h11 * 8'(i);
      tick();
    end
    chk("to_fill", rdata1, 32'hDDCCBBAA);
    tick();
    start1 = 1; mem_din = 8'h5A;
    tick();
    start1 = 0;
    tick();
    mem_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_busy", {busy1, mem_rd1, done1}, 3'b110);
      chk("to_wait_addr", mem_addr1, {16'h0000, 2'd1});
    end
    tick();
    chk("to_done", done1, 1);
    chk("to_err", err1, 1);
    chk("to_rdata", rdata1, 32'hDDCCBB5A);
    tick();
    chk("to_err_hold", err1, 1);
    chk("to_idle", busy1, 0);
    start1 = 1; mem_rdy = 1;
    tick();
    start1 = 0;
    chk("to_err_clr", err1, 0);
    for (int i = 0; i < 5; i++) tick();

    // Reset at beat 2 abandons the transfer.
    start0 = 1; wr = 0; addr_in = 16'h0001; mem_rdy = 1; mem_din = 8'h77;
    tick();
    start0 = 0;
    tick(); tick();
    chk("rst_at_beat2", mem_addr0, {16'h0001, 2'd2});
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_rd", mem_rd0, 0);
    chk("rst_mid_rdata", rdata0, 0);
    chk("rst_mid_done", done0, 0);
    tick();
    chk("rst_no_done", done0, 0);

    // BEATS=8, BYTE_W=4 read with mem_din equal to the beat index.
    start2 = 1; wr = 0; addr_in = 16'h00AB; mem_rdy = 1;
    tick();
    start2 = 0;
    for (int i = 0; i < 8; i++) begin
      chk("b8_addr", mem_addr2, {16'h00AB, 3'(i)});
      mem_din = 8'(i);
      tick();
    end
    chk("b8_done", done2, 1);
    chk("b8_rdata", rdata2, 32'h76543210);
    chk("b8_err", err2, 0);
    tick();
    chk("b8_idle", busy2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
